regfile_param: RTL and testbench

//   Parametrised CPU register file. Replaces the fixed 8x16 file: configurable width, depth
//   and read-port count, R0 hardwired zero, integrated PC register (increment/branch load),

---
 rtl/regfile_param.sv | 136 +++++++++++++
 tb/tb_regfile_param.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised CPU register file: R0 reads as zero, integrated PC, high-part writes,
// and a handshaked debug dump of R1..R(NREGS-1). All state updates on the falling clock edge.
module regfile_param #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NREGS    = 8,
  parameter int unsigned NRD      = 2,
  parameter int unsigned PC_IDX   = 7,
  parameter int unsigned PC_INC   = 2,
  parameter int unsigned HI_W     = 7,
  parameter int unsigned RESET_PC = 0,
  localparam int unsigned IDX_W   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NRD*IDX_W-1:0]  rd_sel,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic                  wr_en,
  input  logic                  wr_hi,
  input  logic [IDX_W-1:0]      wr_sel,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  incr_pc,
  input  logic                  pc_load,
  input  logic [DATA_W-1:0]     pc_target,
  output logic [DATA_W-1:0]     pc,
  input  logic                  dbg_req,
  output logic                  dbg_busy,
  output logic                  dbg_valid,
  input  logic                  dbg_ready,
  output logic [IDX_W-1:0]      dbg_idx,
  output logic [DATA_W-1:0]     dbg_data,
  output logic                  dbg_done
);

  // Bits covered by a high-part write; all ones when HI_W == DATA_W.
  localparam logic [DATA_W-1:0] HI_MASK = ~({DATA_W{1'b1}} >> HI_W);
  localparam logic [IDX_W-1:0]  PC_SEL  = IDX_W'(PC_IDX);

  typedef enum logic [1:0] {IDLE, SEND, DONE} dump_state_t;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] wr_merged;
  logic              wr_hit;
  logic [IDX_W-1:0]  rsel;

  dump_state_t       state_q, state_d;
  logic [IDX_W-1:0]  dbg_idx_q;
  logic [DATA_W-1:0] dbg_data_q;
  logic              dump_start, dump_hs, dump_last;
  logic [IDX_W-1:0]  dbg_idx_next;

  // Widened compare so a power-of-two NREGS does not truncate to zero.
  function automatic logic sel_ok(input logic [IDX_W-1:0] s);
    return (s != '0) && ({1'b0, s} < (IDX_W+1)'(NREGS));
  endfunction

  always_comb begin
    rd_data = '0;
    rsel    = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      rsel = rd_sel[k*IDX_W +: IDX_W];
      if (sel_ok(rsel))
        rd_data[k*DATA_W +: DATA_W] = regs[rsel];
    end
  end

  assign pc     = regs[PC_IDX];
  assign wr_hit = wr_en && sel_ok(wr_sel);

  always_comb begin
    wr_merged = wr_data;
    if (wr_hi)
      wr_merged = (regs[wr_sel] & ~HI_MASK) | ((wr_data << (DATA_W - HI_W)) & HI_MASK);
  end

  // The PC slot is owned by the priority chain; other writes proceed independently.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs[i] <= '0;
      regs[PC_IDX] <= DATA_W'(RESET_PC);
    end else begin
      if (wr_hit && (wr_sel != PC_SEL))
        regs[wr_sel] <= wr_merged;
      if (pc_load)
        regs[PC_IDX] <= pc_target;
      else if (wr_hit && (wr_sel == PC_SEL))
        regs[PC_IDX] <= wr_merged;
      else if (incr_pc)
        regs[PC_IDX] <= regs[PC_IDX] + DATA_W'(PC_INC);
    end
  end

  assign dump_start   = (state_q == IDLE) && dbg_req;
  assign dump_hs      = (state_q == SEND) && dbg_ready;
  assign dump_last    = ({1'b0, dbg_idx_q} == (IDX_W+1)'(NREGS - 1));
  assign dbg_idx_next = dbg_idx_q + 1'b1;

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dbg_req) state_d = SEND;
      SEND:    if (dbg_ready && dump_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dbg_valid = (state_q == SEND);
    dbg_done  = (state_q == DONE);
    dbg_busy  = (state_q != IDLE);
  end

  // Snapshots are taken from the pre-edge register contents.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dbg_idx_q  <= '0;
      dbg_data_q <= '0;
    end else if (dump_start) begin
      dbg_idx_q  <= IDX_W'(1);
      dbg_data_q <= regs[1];
    end else if (dump_hs && !dump_last) begin
      dbg_idx_q  <= dbg_idx_next;
      dbg_data_q <= regs[dbg_idx_next];
    end
  end

  assign dbg_idx  = dbg_idx_q;
  assign dbg_data = dbg_data_q;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed scenarios then random traffic against an array-based model.
module tb_regfile_param;
  localparam int DW = 16, NR = 8, NP = 2, PCI = 7, INC = 2, HW = 7, RPC = 0, IW = 3;

  logic          clk, reset_n;
  logic [NP*IW-1:0] rd_sel;
  logic [NP*DW-1:0] rd_data;
  logic          wr_en, wr_hi, incr_pc, pc_load, dbg_req, dbg_ready;
  logic [IW-1:0] wr_sel;
  logic [DW-1:0] wr_data, pc_target, pc, dbg_data;
  logic          dbg_busy, dbg_valid, dbg_done;
  logic [IW-1:0] dbg_idx;

  regfile_param #(.DATA_W(DW), .NREGS(NR), .NRD(NP), .PC_IDX(PCI), .PC_INC(INC),
                  .HI_W(HW), .RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n), .rd_sel(rd_sel), .rd_data(rd_data),
    .wr_en(wr_en), .wr_hi(wr_hi), .wr_sel(wr_sel), .wr_data(wr_data),
    .incr_pc(incr_pc), .pc_load(pc_load), .pc_target(pc_target), .pc(pc),
    .dbg_req(dbg_req), .dbg_busy(dbg_busy), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
    .dbg_idx(dbg_idx), .dbg_data(dbg_data), .dbg_done(dbg_done));

  initial clk = 1'b1;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [DW-1:0] model [NR];
  bit m_dump, m_done;
  int m_idx;
  logic [DW-1:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mread(input logic [IW-1:0] s);
    if (s == 0 || int'(s) >= NR) return '0;
    return model[s];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = '0;
    model[PCI] = DW'(RPC);
    m_dump = 0; m_done = 0; m_idx = 0; m_data = '0;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_hi = 0; incr_pc = 0; pc_load = 0; dbg_req = 0;
  endtask

  task automatic check_all();
    chk("pc", pc, model[PCI]);
    for (int k = 0; k < NP; k++)
      chk("rd_data", rd_data[k*DW +: DW], mread(rd_sel[k*IW +: IW]));
    chk("dbg_valid", dbg_valid, m_dump);
    chk("dbg_done", dbg_done, m_done);
    chk("dbg_busy", dbg_busy, m_dump | m_done);
    if (m_dump) begin
      chk("dbg_idx", dbg_idx, m_idx);
      chk("dbg_data", dbg_data, m_data);
    end
  endtask

  // Apply the register-file rules to the model for one falling edge, then compare.
  task automatic tick();
    logic [DW-1:0] nm [NR];
    logic [DW-1:0] merged;
    bit hit, nd, ndone;
    int nidx;
    logic [DW-1:0] ndata;
    nm = model;
    hit = wr_en && (wr_sel != 0);
    merged = wr_hi ? DW'((int'(wr_data) % (1 << HW)) * (1 << (DW - HW))
                         + int'(model[wr_sel]) % (1 << (DW - HW)))
                   : wr_data;
    if (hit && wr_sel != PCI) nm[wr_sel] = merged;
    if (pc_load) nm[PCI] = pc_target;
    else if (hit && wr_sel == PCI) nm[PCI] = merged;
    else if (incr_pc) nm[PCI] = DW'((int'(model[PCI]) + INC) % (1 << DW));
    nd = m_dump; ndone = 0; nidx = m_idx; ndata = m_data;
    if (m_done) ndone = 0;
    else if (!m_dump) begin
      if (dbg_req) begin nd = 1; nidx = 1; ndata = model[1]; end
    end else if (dbg_ready) begin
      if (m_idx < NR - 1) begin nidx = m_idx + 1; ndata = model[nidx]; end
      else begin nd = 0; ndone = 1; end
    end
    @(negedge clk); #1;
    model = nm; m_dump = nd; m_done = ndone; m_idx = nidx; m_data = ndata;
    check_all();
  endtask

  task automatic read_all();
    for (int s = 0; s < NR; s++) begin
      rd_sel = {IW'(s), IW'(s)};
      #1;
      chk("read_all0", rd_data[0 +: DW], mread(IW'(s)));
      chk("read_all1", rd_data[DW +: DW], mread(IW'(s)));
    end
  endtask

  task automatic write_reg(input int s, input logic [DW-1:0] d, input bit hi);
    idle_inputs();
    wr_en = 1; wr_hi = hi; wr_sel = IW'(s); wr_data = d;
    tick();
    idle_inputs();
  endtask

  // Asserts reset a couple of ns after a falling edge and checks without any clock edge.
  task automatic reset_mid();
    #1 reset_n = 0;
    #1;
    model_reset();
    chk("rst_pc", pc, DW'(RPC));
    chk("rst_valid", dbg_valid, 1'b0);
    chk("rst_busy", dbg_busy, 1'b0);
    chk("rst_done", dbg_done, 1'b0);
    chk("rst_idx", dbg_idx, 0);
    chk("rst_data", dbg_data, 0);
    for (int p = 0; p < NR / 2; p++) begin
      rd_sel = {IW'(2*p + 1), IW'(2*p)};
      #1;
      chk("rst_rd0", rd_data[0 +: DW], 0);
      chk("rst_rd1", rd_data[DW +: DW], 0);
    end
    reset_n = 1;
  endtask

  initial begin
    idle_inputs();
    dbg_ready = 0; rd_sel = '0; wr_sel = '0; wr_data = '0; pc_target = '0;
    reset_n = 1;
    #2 reset_n = 0;
    model_reset();
    #20 reset_n = 1;
    @(negedge clk); #1;
    check_all();

    for (int i = 1; i < NR; i++) write_reg(i, DW'($urandom), 0);
    rd_sel = {3'd7, 3'd2};
    reset_mid();

    write_reg(3, 16'hBEEF, 0);
    write_reg(3, 16'h0055, 1);
    rd_sel = {3'd0, 3'd3}; #1;
    chk("hi_write", rd_data[0 +: DW], 16'hAAEF);

    write_reg(5, 16'h7777, 0);
    write_reg(0, 16'h1234, 0);
    rd_sel = '0; #1;
    chk("r0_p0", rd_data[0 +: DW], 0);
    chk("r0_p1", rd_data[DW +: DW], 0);
    read_all();

    write_reg(PCI, 16'hFFFE, 0);
    incr_pc = 1; tick(); idle_inputs();
    chk("pc_wrap", pc, 16'h0000);
    pc_load = 1; pc_target = 16'h0100; incr_pc = 1;
    wr_en = 1; wr_sel = 3'd7; wr_data = 16'h5555;
    tick(); idle_inputs();
    chk("pc_prio", pc, 16'h0100);

    for (int i = 1; i < NR; i++) write_reg(i, DW'(i), 0);
    dbg_ready = 0; dbg_req = 1; rd_sel = {3'd1, 3'd7};
    tick();
    dbg_req = 0;
    for (int c = 0; c < 3; c++) tick();
    dbg_ready = 1;
    for (int w = 1; w < NR; w++) tick();
    chk("dump_done", dbg_done, 1'b1);
    tick();
    chk("dump_idle", dbg_busy, 1'b0);

    dbg_ready = 0; dbg_req = 1; tick();
    dbg_req = 0; dbg_ready = 1;
    for (int w = 0; w < 3; w++) tick();
    reset_mid();
    dbg_ready = 0; tick();
    chk("no_done_after_rst", dbg_done, 1'b0);
    dbg_req = 1; tick(); dbg_req = 0;
    chk("restart_idx", dbg_idx, 1);
    dbg_ready = 1;
    for (int w = 0; w < NR + 1; w++) tick();

    for (int n = 0; n < 400; n++) begin
      wr_en = 1'($urandom % 2); wr_hi = ($urandom % 4) == 0;
      wr_sel = IW'($urandom); wr_data = DW'($urandom);
      incr_pc = ($urandom % 3) == 0; pc_load = ($urandom % 8) == 0;
      pc_target = DW'($urandom); dbg_req = ($urandom % 6) == 0;
      dbg_ready = 1'($urandom % 2); rd_sel = (NP*IW)'($urandom);
      tick();
    end
    idle_inputs();
    read_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
